// File: rtl/mem_arbiter.sv
// Two-port line arbiter in front of Data_Memory: data-cache (D) and instruction-fetch (I)
// requesters share one single-outstanding memory handshake, round-robin or D-priority.
module mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,

  input  logic         d_enable_i,
  input  logic         d_write_i,
  input  logic [31:0]  d_addr_i,
  input  logic [255:0] d_data_i,
  output logic         d_ack_o,
  output logic [255:0] d_data_o,

  input  logic         i_enable_i,
  input  logic [31:0]  i_addr_i,
  output logic         i_ack_o,
  output logic [255:0] i_data_o,

  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i,

  output logic         busy_o,
  output logic [1:0]   grant_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  // 1 = instruction port owned the most recent grant
  logic   r_last_i, w_last_i_nxt;
  logic   w_busy_d, w_busy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_last_i <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_last_i <= w_last_i_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_last_i_nxt = r_last_i;
    case (r_state)
      IDLE: begin
        if (d_enable_i && i_enable_i) begin
          if (RR_EN && !r_last_i) begin
            w_state_nxt  = BUSY_I;
            w_last_i_nxt = 1'b1;
          end else begin
            w_state_nxt  = BUSY_D;
            w_last_i_nxt = 1'b0;
          end
        end else if (d_enable_i) begin
          w_state_nxt  = BUSY_D;
          w_last_i_nxt = 1'b0;
        end else if (i_enable_i) begin
          w_state_nxt  = BUSY_I;
          w_last_i_nxt = 1'b1;
        end
      end
      BUSY_D, BUSY_I: begin
        if (mem_ack_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields are not latched; the owner holds them stable until its ack.
  always_comb begin
    w_busy_d     = (r_state == BUSY_D);
    w_busy_i     = (r_state == BUSY_I);
    mem_enable_o = w_busy_d | w_busy_i;
    mem_write_o  = w_busy_d & d_write_i;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    if (w_busy_d) begin
      mem_addr_o = d_addr_i;
      mem_data_o = d_data_i;
    end else if (w_busy_i) begin
      mem_addr_o = i_addr_i;
    end
    d_ack_o  = mem_ack_i & w_busy_d;
    i_ack_o  = mem_ack_i & w_busy_i;
    d_data_o = mem_data_i;
    i_data_o = mem_data_i;
    grant_o  = {w_busy_i, w_busy_d};
    busy_o   = w_busy_d | w_busy_i;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance plus a fixed-priority instance,
// each backed by a line memory that acks three cycles after enable rises.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         d_en, d_wr, i_en;
  logic [31:0]  d_addr, i_addr;
  logic [255:0] d_data;
  logic         force_ack;

  logic         d_ack, i_ack, mem_en, mem_wr, mem_ack, busy;
  logic [255:0] d_q, i_q, mem_wdata, mem_rdata;
  logic [31:0]  mem_addr;
  logic [1:0]   grant;

  logic         f_d_ack, f_i_ack, f_en, f_wr, f_ack, f_busy;
  logic [255:0] f_d_q, f_i_q, f_wdata, f_rdata;
  logic [31:0]  f_addr;
  logic [1:0]   f_grant;

  int unsigned  n_vec = 0;
  int unsigned  n_miss = 0;
  int unsigned  cnt = 0, f_cnt = 0;
  int unsigned  f_i_grants = 0;
  logic         fp_win = 1'b0;
  logic [15:0]  wr_seen = '0;
  logic [255:0] wr_data [16];

  always #5 clk = ~clk;

  mem_arbiter #(.RR_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .d_enable_i(d_en), .d_write_i(d_wr), .d_addr_i(d_addr), .d_data_i(d_data),
    .d_ack_o(d_ack), .d_data_o(d_q),
    .i_enable_i(i_en), .i_addr_i(i_addr), .i_ack_o(i_ack), .i_data_o(i_q),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .busy_o(busy), .grant_o(grant)
  );

  mem_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .d_enable_i(d_en), .d_write_i(d_wr), .d_addr_i(d_addr), .d_data_i(d_data),
    .d_ack_o(f_d_ack), .d_data_o(f_d_q),
    .i_enable_i(i_en), .i_addr_i(i_addr), .i_ack_o(f_i_ack), .i_data_o(f_i_q),
    .mem_enable_o(f_en), .mem_write_o(f_wr), .mem_addr_o(f_addr), .mem_data_o(f_wdata),
    .mem_ack_i(f_ack), .mem_data_i(f_rdata),
    .busy_o(f_busy), .grant_o(f_grant)
  );

  function automatic logic [255:0] init_word(input logic [3:0] k);
    return {8{32'hA5A5_0000 | {28'd0, k}}};
  endfunction

  // Memory models: 32-byte lines, index = addr[8:5]
  always @(posedge clk) begin
    cnt   <= mem_en ? cnt + 1 : 0;
    f_cnt <= f_en ? f_cnt + 1 : 0;
    if (mem_ack && mem_en && mem_wr) begin
      wr_seen[mem_addr[8:5]] <= 1'b1;
      wr_data[mem_addr[8:5]] <= mem_wdata;
    end
    if (fp_win && f_grant[1]) f_i_grants <= f_i_grants + 1;
  end

  always_comb begin
    mem_ack   = (mem_en && cnt == 3) || force_ack;
    mem_rdata = wr_seen[mem_addr[8:5]] ? wr_data[mem_addr[8:5]] : init_word(mem_addr[8:5]);
    f_ack     = f_en && f_cnt == 3;
    f_rdata   = init_word(f_addr[8:5]);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  // One full transaction from the IDLE cycle in which the request is already presented.
  task automatic txn(input string tag, input logic [1:0] g, input logic [31:0] a, input logic w,
                     input logic [255:0] dat, input logic chkfp);
    nc();
    check({tag, ":grant"}, grant, g);
    check({tag, ":en"}, mem_en, 1'b1);
    check({tag, ":addr"}, mem_addr, a);
    check({tag, ":wr"}, mem_wr, w);
    check({tag, ":wdata"}, mem_wdata, g[0] ? d_data : 256'd0);
    if (chkfp) begin
      check({tag, ":fp_grant"}, f_grant, 2'b01);
      check({tag, ":fp_busy"}, f_busy, 1'b1);
      check({tag, ":fp_addr"}, f_addr, d_addr);
      check({tag, ":fp_wr"}, f_wr, 1'b0);
      check({tag, ":fp_wdata"}, f_wdata, d_data);
    end
    repeat (2) begin
      nc();
      check({tag, ":noack"}, {i_ack, d_ack}, 2'b00);
      check({tag, ":busy"}, busy, 1'b1);
    end
    nc();
    check({tag, ":ack"}, {i_ack, d_ack}, g);
    check({tag, ":rdata"}, g[0] ? d_q : i_q, dat);
    if (chkfp) begin
      check({tag, ":fp_ack"}, {f_i_ack, f_d_ack}, 2'b01);
      check({tag, ":fp_rdata"}, f_d_q, init_word(d_addr[8:5]));
      check({tag, ":fp_irdata"}, f_i_q, init_word(d_addr[8:5]));
    end
    nc();
    check({tag, ":idle_busy"}, {busy, mem_en, grant}, 4'b0000);
    check({tag, ":idle_addr"}, mem_addr, 32'd0);
    check({tag, ":idle_wr"}, mem_wr, 1'b0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    nc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; d_en = 0; d_wr = 0; i_en = 0; force_ack = 0;
    d_addr = '0; i_addr = '0; d_data = '0;
    nc(); nc();
    check("rst:ctl", {mem_en, mem_wr, d_ack, i_ack, busy, grant}, 7'd0);
    check("rst:addr", mem_addr, 32'd0);
    check("rst:wdata", mem_wdata, 256'd0);
    rst = 1'b0;

    // D read only
    d_en = 1; d_addr = 32'h0000_0040;
    #1 check("t1:req_cycle_en", mem_en, 1'b0);
    txn("t1", 2'b01, 32'h40, 1'b0, init_word(4'd2), 1'b1);
    d_en = 0;

    // Tie after reset: D, I, D; fixed-priority instance takes D every time
    reset_pulse();
    d_en = 1; i_en = 1; d_addr = 32'h80; i_addr = 32'h100; fp_win = 1;
    txn("t2a", 2'b01, 32'h80, 1'b0, init_word(4'd4), 1'b1);
    txn("t2b", 2'b10, 32'h100, 1'b0, init_word(4'd8), 1'b1);
    txn("t2c", 2'b01, 32'h80, 1'b0, init_word(4'd4), 1'b1);
    d_en = 0; i_en = 0; fp_win = 0;
    check("t3:fp_i_grants", f_i_grants, 0);

    // D write with I pending
    reset_pulse();
    d_en = 1; d_wr = 1; d_data = 256'hECFA; d_addr = 32'h1E0; i_en = 1; i_addr = 32'h20;
    txn("t4a", 2'b01, 32'h1E0, 1'b1, init_word(4'd15), 1'b0);
    txn("t4b", 2'b10, 32'h20, 1'b0, init_word(4'd1), 1'b0);
    txn("t4c", 2'b01, 32'h1E0, 1'b1, 256'hECFA, 1'b0);
    d_en = 0; d_wr = 0; i_en = 0; d_data = '0;

    // Reset in BUSY_I one cycle before ack
    reset_pulse();
    i_en = 1; i_addr = 32'h60;
    nc();
    check("t5:grant_i", grant, 2'b10);
    nc();
    nc();
    rst = 1;
    nc();
    rst = 0; force_ack = 1; d_en = 1; d_addr = 32'h40;
    #1;
    check("t5:post_rst", {busy, mem_en, grant}, 4'b0000);
    check("t5:late_ack", {i_ack, d_ack}, 2'b00);
    force_ack = 0;
    txn("t5", 2'b01, 32'h40, 1'b0, init_word(4'd2), 1'b0);
    d_en = 0; i_en = 0;

    // Spurious ack in IDLE; owner drops enable mid-transaction
    force_ack = 1;
    #1 check("t6:spur_ack", {i_ack, d_ack, busy}, 3'b000);
    nc();
    check("t6:still_idle", busy, 1'b0);
    d_en = 1; d_addr = 32'hA0;
    #1 check("t6:spur_req_ack", d_ack, 1'b0);
    force_ack = 0;
    nc();
    check("t6:grant_d", grant, 2'b01);
    d_en = 0;
    nc();
    nc();
    check("t6:hold", {busy, d_ack}, 2'b10);
    nc();
    check("t6:ack", {i_ack, d_ack}, 2'b01);
    check("t6:rdata", d_q, init_word(4'd5));
    nc();
    check("t6:idle", busy, 1'b0);
    nc();
    check("t6:stay_idle", {busy, grant}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
